pkt_rx_ctrl: RTL and testbench

//   Parametrised receive-packet controller for the DMB GbE/DDU receive path. It sits between
//   the PCS/decoder flag outputs and the RX FIFO/CRC checker, and frames each packet
//   (preamble, payload, CRC check).

---
 rtl/pkt_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_pkt_rx_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pkt_rx_ctrl.sv
// Receive-packet framing controller: preamble/payload/CRC sequencing with runt, giant
// and preamble-timeout detection, plus saturating good/bad/CRC-fail packet counters.
module pkt_rx_ctrl #(
    parameter int MAX_COUNT = 896,
    parameter int MIN_COUNT = 32,
    parameter int PRE_MAX   = 8,
    parameter int LEN_W     = 12,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SOP,
    input  logic             SOF,
    input  logic             EOP,
    input  logic             PRE,
    input  logic             IDLE,
    input  logic             NOK,
    input  logic             CAR_XTEND,
    input  logic             ERR_PROP,
    input  logic             CRC_OK,
    input  logic             CNT_CLR,
    output logic             RXVALID,
    output logic             CLR,
    output logic             CKCRC,
    output logic             DROP,
    output logic             ERR,
    output logic [2:0]       STATE,
    output logic [LEN_W-1:0] LEN,
    output logic [CNT_W-1:0] GOOD_CNT,
    output logic [CNT_W-1:0] BAD_CNT,
    output logic [CNT_W-1:0] CRC_CNT
);

    localparam int PRE_W = $clog2(PRE_MAX + 1);
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_COUNT);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_COUNT);
    localparam logic [PRE_W-1:0] PRE_END = PRE_W'(PRE_MAX - 1);

    typedef enum logic [2:0] {
        S_WAIT_PKT  = 3'd0,
        S_BAD_PKT   = 3'd1,
        S_CKCRC     = 3'd2,
        S_PAYLOAD   = 3'd3,
        S_PREAMBLE  = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t           state, nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic             err_now, rxv, bad_inc, good_inc, crc_inc;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc,
                                              input logic clr);
        if (clr)                    return '0;
        else if (inc && (c != '1)) return c + 1'b1;
        else                        return c;
    endfunction

    always_comb begin
        nxt      = state;
        err_now  = 1'b0;
        rxv      = 1'b0;
        bad_inc  = 1'b0;
        good_inc = 1'b0;
        crc_inc  = 1'b0;
        case (state)
            S_WAIT_PKT: begin
                if (NOK || EOP || CAR_XTEND || ERR_PROP) begin
                    nxt = S_WAIT_IDLE; err_now = 1'b1; bad_inc = 1'b1;
                end else if (SOP && SOF) nxt = S_PAYLOAD;
                else if (SOP)            nxt = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (NOK || ERR_PROP || (!PRE && !SOF) || (pre_cnt == PRE_END && !SOF)) begin
                    nxt = S_BAD_PKT; err_now = 1'b1; bad_inc = 1'b1;
                end else if (SOF) nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // Priority: line error, runt, normal EOP, giant, payload beat
                if (NOK || ERR_PROP || (EOP && LEN < MIN_L)) begin
                    nxt = S_BAD_PKT; err_now = 1'b1; bad_inc = 1'b1;
                end else if (EOP) nxt = S_CKCRC;
                else if (LEN == MAX_L) begin
                    nxt = S_BAD_PKT; err_now = 1'b1; bad_inc = 1'b1;
                end else rxv = 1'b1;
            end
            S_CKCRC: begin
                nxt = S_WAIT_IDLE;
                if (CRC_OK) good_inc = 1'b1;
                else        crc_inc  = 1'b1;
            end
            S_BAD_PKT:   nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (IDLE) nxt = S_WAIT_PKT;
            default:     nxt = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= S_WAIT_PKT;
            pre_cnt  <= '0;
            LEN      <= '0;
            ERR      <= 1'b0;
            GOOD_CNT <= '0;
            BAD_CNT  <= '0;
            CRC_CNT  <= '0;
        end else begin
            state    <= nxt;
            ERR      <= err_now;
            pre_cnt  <= (state == S_PREAMBLE) ? pre_cnt + 1'b1 : '0;
            if (state == S_WAIT_PKT) LEN <= '0;
            else if (rxv)            LEN <= LEN + 1'b1;
            GOOD_CNT <= bump(GOOD_CNT, good_inc, CNT_CLR);
            BAD_CNT  <= bump(BAD_CNT,  bad_inc,  CNT_CLR);
            CRC_CNT  <= bump(CRC_CNT,  crc_inc,  CNT_CLR);
        end
    end

    assign RXVALID = rxv;
    assign CLR     = (state == S_WAIT_PKT);
    assign CKCRC   = (state == S_CKCRC);
    assign DROP    = (state == S_BAD_PKT);
    assign STATE   = state;

endmodule

// File: tb/tb_pkt_rx_ctrl.sv
// Directed bench for pkt_rx_ctrl: good packet, runt, giant, preamble timeout,
// counter clear/saturation and mid-packet reset. Counters built 4 bits wide to reach saturation.
module tb_pkt_rx_ctrl;
    localparam int CNT_W = 4;
    localparam int LEN_W = 12;

    logic clk = 1'b0;
    logic rst_n, sop, sof, eop, pre, idle, nok, car_xtend, err_prop, crc_ok, cnt_clr;
    logic rxvalid, clr, ckcrc, drop, err;
    logic [2:0]       state;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] good_cnt, bad_cnt, crc_cnt;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int rx_seen  = 0;

    always #5 clk = ~clk;

    pkt_rx_ctrl #(.MAX_COUNT(896), .MIN_COUNT(32), .PRE_MAX(8), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST_N(rst_n), .SOP(sop), .SOF(sof), .EOP(eop), .PRE(pre), .IDLE(idle),
        .NOK(nok), .CAR_XTEND(car_xtend), .ERR_PROP(err_prop), .CRC_OK(crc_ok),
        .CNT_CLR(cnt_clr), .RXVALID(rxvalid), .CLR(clr), .CKCRC(ckcrc), .DROP(drop),
        .ERR(err), .STATE(state), .LEN(len), .GOOD_CNT(good_cnt), .BAD_CNT(bad_cnt),
        .CRC_CNT(crc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        sop = 0; sof = 0; eop = 0; pre = 0; idle = 0; nok = 0;
        car_xtend = 0; err_prop = 0; crc_ok = 0; cnt_clr = 0;
    endtask

    // One clock; inputs settle before the edge, outputs sampled 1ns after it
    task automatic tick();
        #1 rx_seen += int'(rxvalid);
        @(posedge clk);
        #1 err_seen += int'(err);
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        err_seen = 0;
        rx_seen  = 0;
    endtask

    task automatic beats(input int n);
        idle_in();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1;
        idle_in();
        @(negedge clk);
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_len", len, 0);
        chk("rst_clr", clr, 1);
        chk("rst_err", err, 0);
        chk("rst_cnts", {good_cnt, bad_cnt, crc_cnt}, 0);

        // 1. good packet with 3 preamble cycles and 40 beats
        sop = 1; tick();
        chk("t1_preamble", state, 4);
        idle_in(); pre = 1;
        tick(); tick(); tick();
        idle_in(); sof = 1; tick();
        chk("t1_payload", state, 3);
        beats(40);
        eop = 1; #1;
        chk("t1_eop_rxv", rxvalid, 0);
        chk("t1_len", len, 40);
        tick();
        idle_in(); crc_ok = 1; #1;
        chk("t1_ckcrc", ckcrc, 1);
        tick();
        chk("t1_ckcrc_1cyc", ckcrc, 0);
        chk("t1_good", good_cnt, 1);
        chk("t1_crc", crc_cnt, 0);
        chk("t1_len_hold", len, 40);
        idle_in(); idle = 1; tick();
        chk("t1_back", state, 0);
        chk("t1_rxv_cnt", rx_seen, 40);
        chk("t1_no_err", err_seen, 0);

        // 2. runt: 10 beats then EOP
        do_reset();
        sop = 1; sof = 1; tick();
        beats(10);
        eop = 1; tick();
        chk("t2_drop", drop, 1);
        chk("t2_err", err, 1);
        chk("t2_bad", bad_cnt, 1);
        chk("t2_no_ckcrc", ckcrc, 0);
        idle_in(); tick();
        chk("t2_drop_1cyc", drop, 0);
        chk("t2_err_pulse", err, 0);
        chk("t2_good", good_cnt, 0);

        // 3. giant: 897 beats, no EOP
        do_reset();
        sop = 1; sof = 1; tick();
        beats(897);
        chk("t3_rxv_cnt", rx_seen, 896);
        chk("t3_drop", drop, 1);
        chk("t3_len", len, 896);
        chk("t3_bad", bad_cnt, 1);
        chk("t3_err", err, 1);
        tick();
        chk("t3_len_hold", len, 896);

        // 4. preamble timeout
        do_reset();
        sop = 1; tick();
        idle_in(); pre = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("t4_still_pre", state, 4);
        tick();
        chk("t4_timeout", state, 1);
        chk("t4_bad", bad_cnt, 1);
        idle_in(); tick();
        chk("t4_wait_idle", state, 5);
        idle = 1; tick();
        chk("t4_back", state, 0);

        // 5a. CRC fail with simultaneous counter clear
        do_reset();
        sop = 1; sof = 1; tick();
        beats(32);
        eop = 1; tick();
        chk("t5_ckcrc", state, 2);
        idle_in(); cnt_clr = 1; tick();
        chk("t5_clr_wins", crc_cnt, 0);
        idle_in(); idle = 1; tick();
        // 5b. CRC fail without clear
        idle_in(); sop = 1; sof = 1; tick();
        beats(32);
        eop = 1; tick();
        idle_in(); tick();
        chk("t5_crc_fail", crc_cnt, 1);
        idle_in(); idle = 1; tick();

        // 6. reset mid-payload at LEN=100
        idle_in(); sop = 1; sof = 1; tick();
        beats(100);
        chk("t6_len100", len, 100);
        rst_n = 0; tick();
        rst_n = 1; #1;
        chk("t6_state", state, 0);
        chk("t6_len", len, 0);
        chk("t6_cnts", {good_cnt, bad_cnt, crc_cnt}, 0);
        chk("t6_rxv", rxvalid, 0);
        chk("t6_clr", clr, 1);

        // 5c. line errors saturate BAD_CNT at all-ones
        do_reset();
        for (int i = 0; i < 17; i++) begin
            idle_in(); eop = 1; tick();
            if (i == 0) chk("t5_line_err", err, 1);
            if (i == 14) chk("t5_bad15", bad_cnt, 15);
            idle_in(); idle = 1; tick();
        end
        chk("t5_bad_sat", bad_cnt, 15);
        idle_in(); cnt_clr = 1; tick();
        chk("t5_bad_clr", bad_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
